// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue with flush
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [ILEN-1:0]            in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [ILEN-1:0]            out_inst,
    output logic [XLEN-1:0]            out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [ILEN-1:0] NOP  = ILEN'(32'h0000_0013);

    logic [ILEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            push;
    logic            pop;

    // Handshake readiness depends only on occupancy, never on the partner's valid.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    assign out_inst = out_valid ? inst_mem[rd_ptr] : NOP;
    assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed bench for fetch_queue
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic [ILEN-1:0] in_inst = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_ready;
    logic            out_valid;
    logic [ILEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic [2:0]      count;

    int passed = 0;
    int total  = 0;
    logic [95:0] mq[$];

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst),
        .in_pc(in_pc), .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    // Reference: a plain FIFO of {inst, pc}; readiness comes from its size before the edge.
    task automatic model_clock();
        int n;
        n = mq.size();
        if (!reset || flush) begin
            mq.delete();
        end else begin
            if (out_ready && n > 0) void'(mq.pop_front());
            if (in_valid && n < DEPTH) mq.push_back({in_inst, in_pc});
        end
    endtask

    function automatic logic [100:0] exp_vec();
        logic [95:0] h;
        int n;
        n = mq.size();
        h = {NOP, 64'h0};
        if (n != 0) h = mq[0];
        return {3'(n), n != 0, n != DEPTH, h[63:0], h[95:64]};
    endfunction

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = $urandom;
        out_ready = rdy;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({count, out_valid, in_ready, out_inst, out_pc} !== {3'd0, 1'b0, 1'b1, NOP, 64'h0})
            $display("FAIL reset_initial got %h exp %h", {count, out_valid, in_ready, out_inst, out_pc}, {3'd0, 1'b0, 1'b1, NOP, 64'h0});
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h40 + 64'(4 * i), 1'b0);
            step();
        end
        total++;
        if (count !== 3'd3) $display("FAIL reset_prefill got %0d exp 3", count);
        else passed++;
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({count, out_valid, in_ready, out_inst, out_pc} !== {3'd0, 1'b0, 1'b1, NOP, 64'h0})
            $display("FAIL reset_midstream got %h exp %h", {count, out_valid, in_ready, out_inst, out_pc}, {3'd0, 1'b0, 1'b1, NOP, 64'h0});
        else passed++;
        step();
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(4 * i), 1'b0);
            step();
        end
        total++;
        if ({count, in_ready, out_pc} !== {3'd4, 1'b0, 64'h0})
            $display("FAIL fill_full got %h exp %h", {count, in_ready, out_pc}, {3'd4, 1'b0, 64'h0});
        else passed++;
        drive(1'b1, 64'h10, 1'b0);
        step();
        total++;
        if ({count, out_pc} !== {3'd4, 64'h0})
            $display("FAIL fill_holdoff got %h exp %h", {count, out_pc}, {3'd4, 64'h0});
        else passed++;
        drive(1'b1, 64'h10, 1'b1);
        step();
        total++;
        if ({count, in_ready, out_pc} !== {3'd3, 1'b1, 64'h4})
            $display("FAIL fill_pop_frees got %h exp %h", {count, in_ready, out_pc}, {3'd3, 1'b1, 64'h4});
        else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1);
            step();
            total++;
            if ({count, out_valid, in_ready, out_pc, out_inst} !== exp_vec())
                $display("FAIL fill_drain got %h exp %h", {count, out_valid, in_ready, out_pc, out_inst}, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 64'h1000 + 64'(4 * i), 1'b1);
            step();
            total++;
            if ({count, out_pc} !== {3'd1, 64'h1000 + 64'(4 * i)})
                $display("FAIL stream_%0d got %h exp %h", i, {count, out_pc}, {3'd1, 64'h1000 + 64'(4 * i)});
            else passed++;
        end
        drive(1'b0, '0, 1'b1);
        step();
        total++;
        if (count !== 3'd0) $display("FAIL stream_drain got %0d exp 0", count);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [XLEN-1:0] sb[$];
        logic [XLEN-1:0] pc;
        int k;
        for (int r = 0; r < 10; r++) begin
            k = $urandom_range(1, DEPTH);
            for (int j = 0; j < k; j++) begin
                pc = {$urandom, $urandom};
                sb.push_back(pc);
                drive(1'b1, pc, 1'b0);
                step();
            end
            for (int j = 0; j < k; j++) begin
                drive(1'b0, '0, 1'b1);
                pc = sb.pop_front();
                total++;
                if (out_pc !== pc) $display("FAIL wrap_order round %0d got %h exp %h", r, out_pc, pc);
                else passed++;
                step();
            end
        end
        total++;
        if ({count, out_valid} !== {3'd0, 1'b0}) $display("FAIL wrap_empty got %h exp 0", {count, out_valid});
        else passed++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h100 + 64'(4 * i), 1'b0);
            step();
        end
        total++;
        if (count !== 3'd3) $display("FAIL flush_prefill got %0d exp 3", count);
        else passed++;
        drive(1'b1, 64'h200, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1})
            $display("FAIL flush_clear got %h exp %h", {count, out_valid, in_ready}, {3'd0, 1'b0, 1'b1});
        else passed++;
        drive(1'b1, 64'h800, 1'b0);
        step();
        in_valid = 1'b0;
        total++;
        if ({count, out_valid, out_pc} !== {3'd1, 1'b1, 64'h800})
            $display("FAIL flush_redirect got %h exp %h", {count, out_valid, out_pc}, {3'd1, 1'b1, 64'h800});
        else passed++;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_empty_pop();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b1);
            step();
            total++;
            if ({count, out_valid, out_pc, out_inst} !== {3'd0, 1'b0, 64'h0, NOP})
                $display("FAIL empty_pop_%0d got %h exp %h", i, {count, out_valid, out_pc, out_inst}, {3'd0, 1'b0, 64'h0, NOP});
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) != 0);
            flush = ($urandom % 16) == 0;
            step();
            total++;
            if ({count, out_valid, in_ready, out_pc, out_inst} !== exp_vec())
                $display("FAIL random_%0d got %h exp %h", i, {count, out_valid, in_ready, out_pc, out_inst}, exp_vec());
            else passed++;
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_wrap();
        test_flush();
        test_empty_pop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
